mont_exp_ctrl: RTL and testbench

- Word-serial modular exponentiation sequencer; computes result = base^exp mod modulus using left-to-right square-and-multiply in the Montgomery domain.
- Sits directly upstream of mont_mult: owns the operand buffers, issues every Montgomery multiplication over the md_start/md_end handshake, and writes each product back into its accumulator.
- Loaded and read by the top-level host over a simple word-addressed port.

---
 rtl/mont_pkg.sv | 20 ++
 rtl/mont_word_buf.sv | 31 +++
 rtl/mont_exp_ctrl.sv | 227 ++++++++++++++++++++++
 tb/tb_mont_exp_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mont_pkg.sv
// Shared definitions for the Montgomery exponentiation sequencer and its buffers.
package mont_pkg;

    localparam int WORD_W        = 32;
    localparam int MAX_WORDS_DEF = 64;

    localparam logic [1:0] SEL_BASE = 2'd0;
    localparam logic [1:0] SEL_EXP  = 2'd1;
    localparam logic [1:0] SEL_MOD  = 2'd2;
    localparam logic [1:0] SEL_R2   = 2'd3;

    typedef enum logic [2:0] {
        IDLE, CHECK, ISSUE, FEED, WAIT, COLLECT, NEXT, FINISH
    } state_t;

    typedef enum logic [2:0] {
        ACC_IN, BASE_IN, SQR, MUL, FROM
    } op_t;

endpackage

// File: rtl/mont_word_buf.sv
// Operand word buffer: one write port, two combinational read ports.
// Deliberately not reset; the host reloads contents before use.
module mont_word_buf
    import mont_pkg::*;
#(
    parameter int DEPTH  = MAX_WORDS_DEF,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [WORD_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr_a,
    output logic [WORD_W-1:0] o_rdata_a,
    input  logic [ADDR_W-1:0] i_raddr_b,
    output logic [WORD_W-1:0] o_rdata_b
);

    logic [WORD_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we && (int'(i_waddr) < DEPTH)) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Out-of-range reads return zero rather than an undefined entry.
    assign o_rdata_a = (int'(i_raddr_a) < DEPTH) ? r_mem[i_raddr_a] : '0;
    assign o_rdata_b = (int'(i_raddr_b) < DEPTH) ? r_mem[i_raddr_b] : '0;

endmodule

// File: rtl/mont_exp_ctrl.sv
// Modular exponentiation sequencer: left-to-right square-and-multiply in the
// Montgomery domain, streaming operands to mont_mult one word per cycle.
//
// state   | meaning
// IDLE    | wait for start, latch len / exp_bits
// CHECK   | validate len
// ISSUE   | pulse md_start, clear word counter
// FEED    | stream operand words 0..len-1
// WAIT    | wait for md_end, capture result word 0
// COLLECT | capture result words 1..len-1
// NEXT    | select next op and exponent bit
// FINISH  | done pulse, err valid
module mont_exp_ctrl
    import mont_pkg::*;
#(
    parameter int MAX_WORDS = MAX_WORDS_DEF,
    parameter int ADDR_W    = 6,
    parameter int EXPB_W    = 14
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic [7:0]        len,
    input  logic [EXPB_W-1:0] exp_bits,
    input  logic              wr_en,
    input  logic [1:0]        wr_sel,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [31:0]       wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [31:0]       rd_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              md_start,
    output logic [7:0]        md_len,
    output logic [31:0]       num_1,
    output logic [31:0]       num_2,
    output logic [31:0]       modulus_o,
    input  logic              md_end,
    input  logic [31:0]       mm_in
);

    state_t            r_state, w_state_nxt;
    op_t               r_op, w_op_nxt;
    logic [EXPB_W-1:0] r_bit, w_bit_nxt;
    logic [EXPB_W-1:0] r_expb, w_expb_nxt;
    logic [7:0]        r_len, w_len_nxt;
    logic [7:0]        r_cnt, w_cnt_nxt;
    logic              r_err, w_err_nxt;
    logic [31:0]       r_rd_data;
    logic              w_wb_we;
    logic              w_host_we;
    logic              w_last;
    logic              w_exp_bit;
    logic [31:0]       w_one;
    logic [ADDR_W-1:0] w_cnt_addr;
    logic [ADDR_W-1:0] w_exp_addr;
    logic [31:0]       w_base_a, w_exp_a, w_mod_a, w_r2_a, w_acc_a, w_basem_a;
    logic [31:0]       w_base_b, w_exp_b, w_mod_b, w_r2_b, w_acc_b, w_basem_b;

    assign busy       = (r_state != IDLE) && (r_state != FINISH);
    assign done       = (r_state == FINISH);
    assign err        = done && r_err;
    assign md_start   = (r_state == ISSUE);
    assign md_len     = r_len;
    assign rd_data    = r_rd_data;
    assign w_host_we  = wr_en && !busy;
    assign w_last     = (r_cnt == r_len - 8'd1);
    assign w_cnt_addr = r_cnt[ADDR_W-1:0];
    assign w_exp_addr = r_bit[ADDR_W+4:5];
    assign w_exp_bit  = w_exp_a[r_bit[4:0]];
    assign w_one      = (r_cnt == 8'd0) ? 32'd1 : 32'd0;

    mont_word_buf #(.DEPTH(MAX_WORDS), .ADDR_W(ADDR_W)) u_base (
        .clk(clk), .i_we(w_host_we && (wr_sel == SEL_BASE)), .i_waddr(wr_addr), .i_wdata(wr_data),
        .i_raddr_a(w_cnt_addr), .o_rdata_a(w_base_a), .i_raddr_b(rd_addr), .o_rdata_b(w_base_b));

    mont_word_buf #(.DEPTH(MAX_WORDS), .ADDR_W(ADDR_W)) u_exp (
        .clk(clk), .i_we(w_host_we && (wr_sel == SEL_EXP)), .i_waddr(wr_addr), .i_wdata(wr_data),
        .i_raddr_a(w_exp_addr), .o_rdata_a(w_exp_a), .i_raddr_b(rd_addr), .o_rdata_b(w_exp_b));

    mont_word_buf #(.DEPTH(MAX_WORDS), .ADDR_W(ADDR_W)) u_mod (
        .clk(clk), .i_we(w_host_we && (wr_sel == SEL_MOD)), .i_waddr(wr_addr), .i_wdata(wr_data),
        .i_raddr_a(w_cnt_addr), .o_rdata_a(w_mod_a), .i_raddr_b(rd_addr), .o_rdata_b(w_mod_b));

    mont_word_buf #(.DEPTH(MAX_WORDS), .ADDR_W(ADDR_W)) u_r2 (
        .clk(clk), .i_we(w_host_we && (wr_sel == SEL_R2)), .i_waddr(wr_addr), .i_wdata(wr_data),
        .i_raddr_a(w_cnt_addr), .o_rdata_a(w_r2_a), .i_raddr_b(rd_addr), .o_rdata_b(w_r2_b));

    // Product write-back shares the word counter; operands were fully streamed before md_end.
    mont_word_buf #(.DEPTH(MAX_WORDS), .ADDR_W(ADDR_W)) u_acc (
        .clk(clk), .i_we(w_wb_we && (r_op != BASE_IN)), .i_waddr(w_cnt_addr), .i_wdata(mm_in),
        .i_raddr_a(w_cnt_addr), .o_rdata_a(w_acc_a), .i_raddr_b(rd_addr), .o_rdata_b(w_acc_b));

    mont_word_buf #(.DEPTH(MAX_WORDS), .ADDR_W(ADDR_W)) u_basem (
        .clk(clk), .i_we(w_wb_we && (r_op == BASE_IN)), .i_waddr(w_cnt_addr), .i_wdata(mm_in),
        .i_raddr_a(w_cnt_addr), .o_rdata_a(w_basem_a), .i_raddr_b(rd_addr), .o_rdata_b(w_basem_b));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
            r_op    <= ACC_IN;
            r_bit   <= '0;
            r_expb  <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_op    <= w_op_nxt;
            r_bit   <= w_bit_nxt;
            r_expb  <= w_expb_nxt;
            r_len   <= w_len_nxt;
            r_cnt   <= w_cnt_nxt;
            r_err   <= w_err_nxt;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= w_acc_b;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_op_nxt    = r_op;
        w_bit_nxt   = r_bit;
        w_expb_nxt  = r_expb;
        w_len_nxt   = r_len;
        w_cnt_nxt   = r_cnt;
        w_err_nxt   = r_err;
        w_wb_we     = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_len_nxt   = len;
                    w_expb_nxt  = exp_bits;
                    w_err_nxt   = 1'b0;
                    w_state_nxt = CHECK;
                end
            end
            CHECK: begin
                if ((r_len == 8'd0) || (r_len > 8'(MAX_WORDS))) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = FINISH;
                end else begin
                    w_op_nxt    = ACC_IN;
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                w_cnt_nxt   = '0;
                w_state_nxt = FEED;
            end
            FEED: begin
                if (w_last) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = WAIT;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            WAIT: begin
                if (md_end) begin
                    w_wb_we     = 1'b1;
                    w_cnt_nxt   = r_cnt + 8'd1;
                    w_state_nxt = (r_len == 8'd1) ? NEXT : COLLECT;
                end
            end
            COLLECT: begin
                w_wb_we = 1'b1;
                if (w_last) begin
                    w_state_nxt = NEXT;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            NEXT: begin
                w_state_nxt = ISSUE;
                case (r_op)
                    ACC_IN: w_op_nxt = BASE_IN;
                    BASE_IN: begin
                        if (r_expb == '0) begin
                            w_op_nxt = FROM;
                        end else begin
                            w_op_nxt  = SQR;
                            w_bit_nxt = r_expb - EXPB_W'(1);
                        end
                    end
                    FROM: w_state_nxt = FINISH;
                    default: begin
                        if ((r_op == SQR) && w_exp_bit) begin
                            w_op_nxt = MUL;
                        end else if (r_bit == '0) begin
                            w_op_nxt = FROM;
                        end else begin
                            w_op_nxt  = SQR;
                            w_bit_nxt = r_bit - EXPB_W'(1);
                        end
                    end
                endcase
            end
            FINISH: w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        num_1     = '0;
        num_2     = '0;
        modulus_o = '0;
        if (r_state == FEED) begin
            modulus_o = w_mod_a;
            case (r_op)
                ACC_IN:  begin num_1 = w_one;    num_2 = w_r2_a;    end
                BASE_IN: begin num_1 = w_base_a; num_2 = w_r2_a;    end
                SQR:     begin num_1 = w_acc_a;  num_2 = w_acc_a;   end
                MUL:     begin num_1 = w_acc_a;  num_2 = w_basem_a; end
                default: begin num_1 = w_acc_a;  num_2 = w_one;     end
            endcase
        end
    end

endmodule

// File: tb/tb_mont_exp_ctrl.sv
// Directed bench for mont_exp_ctrl with a behavioural mont_mult (bitwise REDC).
module tb_mont_exp_ctrl;
    import mont_pkg::*;

    localparam int ADDR_W = 6;
    localparam int EXPB_W = 14;
    localparam logic [63:0] N3 = 64'h0000_0001_0000_0007;

    logic              clk = 1'b0;
    logic              rstn;
    logic              start;
    logic [7:0]        len;
    logic [EXPB_W-1:0] exp_bits;
    logic              wr_en;
    logic [1:0]        wr_sel;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic [ADDR_W-1:0] rd_addr;
    logic [31:0]       rd_data;
    logic              busy, done, err, md_start;
    logic [7:0]        md_len;
    logic [31:0]       num_1, num_2, modulus_o;
    logic              md_end;
    logic [31:0]       mm_in;

    int n_checks = 0;
    int n_errors = 0;
    int n_mdstart = 0;
    int cur_len = 1;
    int md_delay = 1;
    int rst_gen = 0;
    bit spurious = 1'b0;

    logic [63:0] r2_3;
    logic [255:0] big;
    logic ok, err_v;

    mont_exp_ctrl dut (
        .clk(clk), .rstn(rstn), .start(start), .len(len), .exp_bits(exp_bits),
        .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .done(done), .err(err),
        .md_start(md_start), .md_len(md_len), .num_1(num_1), .num_2(num_2),
        .modulus_o(modulus_o), .md_end(md_end), .mm_in(mm_in)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] mont_mul(input logic [63:0] a, input logic [63:0] b,
                                             input logic [63:0] n, input int nw);
        logic [255:0] p, wa, wb, wn;
        wa = {192'd0, a};
        wb = {192'd0, b};
        wn = {192'd0, n};
        p  = wa * wb;
        for (int i = 0; i < 32 * nw; i++) begin
            if (p[0]) p = p + wn;
            p = p >> 1;
        end
        if (p >= wn) p = p - wn;
        return p[63:0];
    endfunction

    // Behavioural mont_mult: operands at T+1+i, md_end md_delay cycles after the last word.
    initial begin : mm_model
        logic [63:0] a, b, n, res;
        int my_gen;
        md_end = 1'b0;
        mm_in  = '0;
        forever begin
            @(negedge clk);
            if (md_start) begin
                n_mdstart++;
                my_gen = rst_gen;
                a = '0; b = '0; n = '0;
                for (int i = 0; i < cur_len; i++) begin
                    @(negedge clk);
                    if (spurious && i == 0) begin
                        md_end = 1'b1; mm_in = 32'hdead_beef;
                    end else begin
                        md_end = 1'b0; mm_in = '0;
                    end
                    a[i*32 +: 32] = num_1;
                    b[i*32 +: 32] = num_2;
                    n[i*32 +: 32] = modulus_o;
                end
                res = mont_mul(a, b, n, cur_len);
                for (int d = 0; d < md_delay; d++) begin
                    @(negedge clk);
                    md_end = 1'b0; mm_in = '0;
                end
                if (my_gen == rst_gen) begin
                    md_end = 1'b1; mm_in = res[31:0];
                    @(negedge clk);
                    md_end = 1'b0;
                    for (int i = 1; i < cur_len; i++) begin
                        mm_in = res[i*32 +: 32];
                        @(negedge clk);
                    end
                    mm_in = '0;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, expv);
        end
    endtask

    task automatic wr_word(input logic [1:0] sel, input int addr, input logic [31:0] data);
        wr_en = 1'b1; wr_sel = sel; wr_addr = addr[ADDR_W-1:0]; wr_data = data;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic load(input int l, input logic [63:0] b, input logic [63:0] e,
                        input logic [63:0] m, input logic [63:0] r);
        for (int i = 0; i < l; i++) begin
            wr_word(SEL_BASE, i, b[i*32 +: 32]);
            wr_word(SEL_EXP,  i, e[i*32 +: 32]);
            wr_word(SEL_MOD,  i, m[i*32 +: 32]);
            wr_word(SEL_R2,   i, r[i*32 +: 32]);
        end
    endtask

    task automatic start_op(input int l, input int eb);
        len = l[7:0]; exp_bits = eb[EXPB_W-1:0]; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output logic ok_o, output logic err_o);
        ok_o = 1'b0; err_o = 1'b0;
        for (int c = 0; c < 5000 && !ok_o; c++) begin
            @(negedge clk);
            if (done) begin ok_o = 1'b1; err_o = err; end
        end
    endtask

    task automatic rd_chk(input string tag, input int addr, input logic [31:0] expv);
        rd_addr = addr[ADDR_W-1:0];
        @(negedge clk);
        chk(tag, rd_data, expv);
    endtask

    task automatic run_chk(input string tag, input int l, input int eb, input int pulses,
                           input logic [63:0] res);
        logic o, e;
        n_mdstart = 0;
        start_op(l, eb);
        wait_done(o, e);
        chk({tag, "_done"}, o, 1);
        chk({tag, "_err"}, e, 0);
        chk({tag, "_pulses"}, n_mdstart, pulses);
        for (int i = 0; i < l; i++) rd_chk({tag, "_res"}, i, res[i*32 +: 32]);
    endtask

    task automatic err_run(input string tag, input int l);
        n_mdstart = 0;
        start_op(l, 3);
        chk({tag, "_c1_done"}, done, 0);
        @(negedge clk);
        chk({tag, "_c2_done"}, done, 1);
        chk({tag, "_c2_err"}, err, 1);
        chk({tag, "_c2_busy"}, busy, 0);
        @(negedge clk);
        chk({tag, "_pulse1"}, done, 0);
        chk({tag, "_no_md"}, n_mdstart, 0);
    endtask

    initial begin
        rstn = 1'b0; start = 1'b0; len = '0; exp_bits = '0;
        wr_en = 1'b0; wr_sel = '0; wr_addr = '0; wr_data = '0; rd_addr = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_md_start", md_start, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_ops", {num_1, num_2}, 0);
        chk("rst_mod", modulus_o, 0);
        chk("rst_md_len", md_len, 0);
        rstn = 1'b1;
        @(negedge clk);

        // 7^5 mod 13 = 11
        cur_len = 1; md_delay = 1; spurious = 1'b0;
        load(1, 64'd7, 64'd5, 64'd13, 64'd3);
        run_chk("t1", 1, 3, 8, 64'd11);

        // Same vector with late md_end, a spurious md_end in FEED, and host traffic while busy
        md_delay = 40; spurious = 1'b1; n_mdstart = 0;
        start_op(1, 3);
        chk("t1b_busy", busy, 1);
        chk("t1b_md_len", md_len, 1);
        wr_en = 1'b1; wr_sel = SEL_BASE; wr_addr = '0; wr_data = 32'd3;
        len = 8'd0; start = 1'b1;
        @(negedge clk);
        wr_en = 1'b0; start = 1'b0;
        wait_done(ok, err_v);
        chk("t1b_done", ok, 1);
        chk("t1b_err", err_v, 0);
        chk("t1b_pulses", n_mdstart, 8);
        rd_chk("t1b_res", 0, 32'd11);

        md_delay = 1; spurious = 1'b0;
        run_chk("t2", 1, 0, 3, 64'd1);

        // 2^16 mod (2^32+7), two words
        big  = (256'd1 << 128) % {192'd0, N3};
        r2_3 = big[63:0];
        cur_len = 2;
        load(2, 64'd2, 64'h10, N3, r2_3);
        run_chk("t3", 2, 5, 9, 64'h0000_0000_0001_0000);
        md_delay = 40; spurious = 1'b1;
        run_chk("t3b", 2, 5, 9, 64'h0000_0000_0001_0000);
        md_delay = 1; spurious = 1'b0;

        err_run("len0", 0);
        err_run("len65", 65);

        // Reset pulse while waiting on mont_mult
        md_delay = 40; n_mdstart = 0;
        start_op(2, 5);
        for (int c = 0; c < 20 && n_mdstart == 0; c++) @(negedge clk);
        chk("t5_issued", n_mdstart, 1);
        repeat (6) @(negedge clk);
        chk("t5_busy_pre", busy, 1);
        rstn = 1'b0;
        #1;
        chk("t5_busy", busy, 0);
        chk("t5_done", done, 0);
        chk("t5_md_start", md_start, 0);
        chk("t5_md_len", md_len, 0);
        rst_gen++;
        @(negedge clk);
        rstn = 1'b1;
        repeat (50) begin
            @(negedge clk);
            if (done) chk("t5_no_done", done, 0);
        end
        md_delay = 1;
        load(2, 64'd2, 64'h10, N3, r2_3);
        run_chk("t5_rerun", 2, 5, 9, 64'h0000_0000_0001_0000);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
